// File: rtl/alu_byte_sequencer.sv
// Byte-stream front end for a combinational ALU: gathers A, B and opcode, runs the ALU, returns the result byte.
// Optional build macro CARRY_REPORT_EN appends a carry byte after each valid result.
module alu_byte_sequencer #(
  parameter int          SIZE     = 8,
  parameter int          NB_OP    = 6,
  parameter logic [7:0]  ERR_CODE = 8'hEE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic [SIZE-1:0]   o_alu_a,
  output logic [SIZE-1:0]   o_alu_b,
  output logic [NB_OP-1:0]  o_alu_op,
  input  logic [SIZE-1:0]   i_alu_res,
  input  logic              i_alu_carry,
  output logic              o_err
);

`ifdef CARRY_REPORT_EN
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_TX_RES, S_TX_CRY} state_t;
`else
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_TX_RES} state_t;
`endif

  state_t state_reg;
  logic   settle_reg;
  logic   rx_fire;
  logic   tx_fire;

  assign rx_fire = i_rx_valid & o_rx_ready;
  assign tx_fire = o_tx_valid & i_tx_ready;

`ifdef CARRY_REPORT_EN
  logic carry_reg;
  logic err_seq_reg;
`else
  logic unused_carry;
  assign unused_carry = i_alu_carry;
`endif

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: op_supported = 1'b1;
      default:                                                 op_supported = 1'b0;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= S_A;
      settle_reg  <= 1'b0;
      o_rx_ready  <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= 8'h00;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_err       <= 1'b0;
`ifdef CARRY_REPORT_EN
      carry_reg   <= 1'b0;
      err_seq_reg <= 1'b0;
`endif
    end else begin
      o_err <= 1'b0;
      case (state_reg)
        S_A: begin
          o_rx_ready <= 1'b1;
          if (rx_fire) begin
            o_alu_a   <= i_rx_data[SIZE-1:0];
            state_reg <= S_B;
          end
        end
        S_B: begin
          o_rx_ready <= 1'b1;
          if (rx_fire) begin
            o_alu_b   <= i_rx_data[SIZE-1:0];
            state_reg <= S_OP;
          end
        end
        S_OP: begin
          o_rx_ready <= 1'b1;
          if (rx_fire) begin
            o_rx_ready <= 1'b0;
            if (op_supported(i_rx_data[5:0])) begin
              o_alu_op   <= NB_OP'(i_rx_data[5:0]);
              settle_reg <= 1'b0;
              state_reg  <= S_EXEC;
`ifdef CARRY_REPORT_EN
              err_seq_reg <= 1'b0;
`endif
            end else begin
              o_tx_data  <= ERR_CODE;
              o_tx_valid <= 1'b1;
              o_err      <= 1'b1;
              state_reg  <= S_TX_RES;
`ifdef CARRY_REPORT_EN
              err_seq_reg <= 1'b1;
`endif
            end
          end
        end
        // First cycle lets the freshly registered opcode propagate; capture on the second.
        S_EXEC: begin
          if (!settle_reg) begin
            settle_reg <= 1'b1;
          end else begin
            o_tx_data  <= 8'($signed(i_alu_res));
            o_tx_valid <= 1'b1;
            state_reg  <= S_TX_RES;
`ifdef CARRY_REPORT_EN
            carry_reg  <= i_alu_carry;
`endif
          end
        end
        S_TX_RES: begin
          if (tx_fire) begin
`ifdef CARRY_REPORT_EN
            if (!err_seq_reg) begin
              o_tx_data <= {7'b0, carry_reg};
              state_reg <= S_TX_CRY;
            end else begin
              o_tx_valid <= 1'b0;
              o_rx_ready <= 1'b1;
              state_reg  <= S_A;
            end
`else
            o_tx_valid <= 1'b0;
            o_rx_ready <= 1'b1;
            state_reg  <= S_A;
`endif
          end
        end
`ifdef CARRY_REPORT_EN
        S_TX_CRY: begin
          if (tx_fire) begin
            o_tx_valid <= 1'b0;
            o_rx_ready <= 1'b1;
            state_reg  <= S_A;
          end
        end
`endif
        default: begin
          o_tx_valid <= 1'b0;
          o_rx_ready <= 1'b0;
          state_reg  <= S_A;
        end
      endcase
    end
  end

endmodule
